sram_like_slave: RTL and testbench

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

---
 rtl/sram_like_slave_pkg.sv | 22 ++
 rtl/sram_resp_fifo.sv | 76 +++++++
 rtl/sram_like_slave.sv | 117 +++++++++++
 tb/tb_sram_like_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_slave_pkg.sv
// Shared definitions for the SRAM-like slave: bus widths, LFSR polynomial,
// default LFSR seed and the LFSR step function.
package sram_like_slave_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int SIZE_W = 2;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback taps on bits 7,5,4,3
    localparam int                LFSR_W            = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 8'h5a;

    // response delay counter is loaded from two LFSR bits
    localparam int DLY_W = 2;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue for sram_like_slave.
//   clk, reset      : clock, asynchronous active-high reset (pointers/count cleared)
//   push, push_data : enqueue one 32-bit response (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head_data       : current head entry
//   empty, full     : occupancy flags
//   count           : number of entries held (0..DEPTH)
module sram_resp_fifo
    import sram_like_slave_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = slot_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: an entry is only visible after being pushed
    always_ff @(posedge clk) begin
        if (do_push) begin
            slot_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like bus slave backed by a 2^AW x 32-bit internal memory.
//   clk, reset    : clock, asynchronous active-high reset
//   req, wr       : request valid, 1 = write / 0 = read
//   size          : transfer size (not used; writes are governed by wstrb)
//   addr          : byte address, word index addr[AW+1:2] (upper bits wrap)
//   wstrb, wdata  : write byte enables and data
//   addr_ok       : request accepted this cycle when req=1
//   data_ok       : one response returned this cycle (always consumed)
//   rdata         : read data for the response, 0 when data_ok=0
// Every accepted request yields one in-order response; writes answer with 0.
// With RAND_EN=1 an LFSR injects addr_ok stalls and per-response delays.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int                AW      = 12,
    parameter int                DEPTH   = 2,
    parameter bit                RAND_EN = 1'b0,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [SIZE_W-1:0] size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [DATA_W-1:0] mem_q [2**AW];

    logic [AW-1:0]     word_idx;
    logic              stall;
    logic              hs;
    logic              pop;
    logic              becomes_head;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] head_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_bits;

    assign word_idx    = addr[AW+1:2];
    assign unused_bits = ^{size, addr[ADDR_W-1:AW+2], addr[1:0]};

    // acceptance depends only on registered state; held low while in reset
    assign stall   = RAND_EN && lfsr_q[0] && lfsr_q[1];
    assign addr_ok = !reset && !fifo_full && !stall;
    assign hs      = req && addr_ok;

    assign pop     = !fifo_empty && (dly_q == '0);
    assign data_ok = pop;
    assign rdata   = pop ? head_data : '0;

    // read data is sampled from memory at the accepting edge
    assign push_data = wr ? '0 : mem_q[word_idx];

    // a new head appears when the queue was empty and gets a push, or when the
    // head pops and something (already queued or arriving now) takes its place
    assign becomes_head = (fifo_empty && hs)
                       || (pop && ((fifo_count > CNT_W'(1)) || hs));

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        dly_d  = dly_q;
        if (becomes_head) begin
            dly_d = RAND_EN ? lfsr_q[3:2] : '0;
        end else if (dly_q != '0) begin
            dly_d = dly_q - DLY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
            dly_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            dly_q  <= dly_d;
        end
    end

    // memory contents survive reset
    always_ff @(posedge clk) begin
        if (hs && wr) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    sram_resp_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hs),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_like_slave.sv
`timescale 1ns/1ps
module tb_sram_like_slave;

    localparam int         AW    = 12;
    localparam int         DEPTH = 2;
    localparam logic [7:0] SEED  = 8'h5a;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance 0: deterministic timing
    logic        d0_req = 0, d0_wr = 0;
    logic [1:0]  d0_size = 0;
    logic [31:0] d0_addr = 0, d0_wdata = 0;
    logic [3:0]  d0_wstrb = 0;
    logic        d0_addr_ok, d0_data_ok;
    logic [31:0] d0_rdata;

    // instance 1: random stalls and delays
    logic        d1_req = 0, d1_wr = 0;
    logic [1:0]  d1_size = 0;
    logic [31:0] d1_addr = 0, d1_wdata = 0;
    logic [3:0]  d1_wstrb = 0;
    logic        d1_addr_ok, d1_data_ok;
    logic [31:0] d1_rdata;

    sram_like_slave #(.AW(AW), .DEPTH(DEPTH), .RAND_EN(1'b0), .SEED(SEED)) u_dut0 (
        .clk(clk), .reset(reset), .req(d0_req), .wr(d0_wr), .size(d0_size),
        .addr(d0_addr), .wstrb(d0_wstrb), .wdata(d0_wdata),
        .addr_ok(d0_addr_ok), .data_ok(d0_data_ok), .rdata(d0_rdata)
    );

    sram_like_slave #(.AW(AW), .DEPTH(DEPTH), .RAND_EN(1'b1), .SEED(SEED)) u_dut1 (
        .clk(clk), .reset(reset), .req(d1_req), .wr(d1_wr), .size(d1_size),
        .addr(d1_addr), .wstrb(d1_wstrb), .wdata(d1_wdata),
        .addr_ok(d1_addr_ok), .data_ok(d1_data_ok), .rdata(d1_rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] apply_strobes(input logic [31:0] old, input logic [31:0] d,
                                                  input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hff << (8 * b));
        return (old & ~m) | (d & m);
    endfunction

    // Maximal-length polynomial x^8+x^6+x^5+x^4+1: the new bit is the parity
    // of the stages feeding powers 8,6,5,4 (bits 7,5,4,3), shifted in at bit 0.
    function automatic logic [7:0] poly_step(input logic [7:0] s);
        int v, fb;
        v  = int'(s);
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v << 1) | fb) & 255);
    endfunction

    // ---------------- reference model for instance 1 ----------------
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [int];
    logic [7:0]  ref_lfsr = SEED;
    logic        exp_ok_m;
    int          idx_m;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            ref_lfsr = SEED;
            chk("d1_addr_ok_reset", {31'b0, d1_addr_ok}, 32'd0);
            chk("d1_data_ok_reset", {31'b0, d1_data_ok}, 32'd0);
            chk("d1_rdata_reset", d1_rdata, 32'd0);
        end else begin
            exp_ok_m = (exp_q.size() < DEPTH) && !(ref_lfsr[0] && ref_lfsr[1]);
            chk("d1_addr_ok", {31'b0, d1_addr_ok}, {31'b0, exp_ok_m});
            if (d1_data_ok) begin
                if (exp_q.size() == 0) chk("d1_data_ok_unexpected", {31'b0, d1_data_ok}, 32'd0);
                else chk("d1_rdata_order", d1_rdata, exp_q.pop_front());
            end else begin
                chk("d1_rdata_idle", d1_rdata, 32'd0);
            end
            if (d1_req && d1_addr_ok) begin
                idx_m = int'((d1_addr / 4) % (32'd1 << AW));
                if (d1_wr) begin
                    ref_mem[idx_m] = apply_strobes(ref_mem.exists(idx_m) ? ref_mem[idx_m] : 32'h0,
                                                   d1_wdata, d1_wstrb);
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(ref_mem.exists(idx_m) ? ref_mem[idx_m] : 32'h0);
                end
            end
            ref_lfsr = poly_step(ref_lfsr);
        end
    end

    // ---------------- instance 0 directed vectors ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic d0_txn(input vec_t v, input int k);
        d0_req = 1; d0_wr = v.wr; d0_addr = v.addr; d0_wstrb = v.strb; d0_wdata = v.wdata;
        d0_size = 2'($urandom_range(0, 3));
        @(negedge clk);
        chk($sformatf("d0_addr_ok[%0d]", k), {31'b0, d0_addr_ok}, 32'd1);
        chk($sformatf("d0_no_early_data[%0d]", k), {31'b0, d0_data_ok}, 32'd0);
        @(posedge clk); #1;
        d0_req = 0;
        @(negedge clk);
        chk($sformatf("d0_data_ok[%0d]", k), {31'b0, d0_data_ok}, 32'd1);
        chk($sformatf("d0_rdata[%0d]", k), d0_rdata, v.exp);
        @(posedge clk); #1;
    endtask

    task automatic d1_op(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n;
        n = 0;
        d1_req = 1; d1_wr = w; d1_addr = a; d1_wstrb = s; d1_wdata = d;
        d1_size = 2'($urandom_range(0, 3));
        @(negedge clk);
        while (!d1_addr_ok && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("d1_accept_within_bound", {31'b0, d1_addr_ok}, 32'd1);
        @(posedge clk); #1;
        d1_req = 0;
    endtask

    initial begin
        int n;
        logic [31:0] a;

        vecs[0]  = '{1'b1, 32'h0000_0100, 4'hf,    32'h1234_5678, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 4'h0,    32'h0,         32'h1234_5678};
        vecs[2]  = '{1'b1, 32'h0000_0100, 4'b0010, 32'h0000_AB00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0100, 4'h0,    32'h0,         32'h1234_AB78};
        vecs[4]  = '{1'b1, 32'h0000_0000, 4'hf,    32'hDEAD_BEEF, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_4000, 4'h0,    32'h0,         32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h0000_0004, 4'hf,    32'h1122_3344, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0004, 4'b1001, 32'hAABB_CCDD, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0004, 4'h0,    32'h0,         32'hAA22_33DD};
        vecs[9]  = '{1'b1, 32'h0000_0008, 4'hf,    32'h5566_7788, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0008, 4'h0,    32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_000B, 4'h0,    32'h0,         32'h5566_7788};
        vecs[12] = '{1'b1, 32'hFFFF_FFFC, 4'hf,    32'hCAFE_F00D, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_3FFC, 4'h0,    32'h0,         32'hCAFE_F00D};

        // reset state
        @(negedge clk);
        chk("d0_addr_ok_reset", {31'b0, d0_addr_ok}, 32'd0);
        chk("d0_data_ok_reset", {31'b0, d0_data_ok}, 32'd0);
        chk("d0_rdata_reset", d0_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("d0_addr_ok_after_reset", {31'b0, d0_addr_ok}, 32'd1);
        chk("d0_data_ok_after_reset", {31'b0, d0_data_ok}, 32'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) d0_txn(vecs[i], i);

        // three pipelined reads with req held high
        d0_req = 1; d0_wr = 0; d0_addr = 32'h0;
        @(negedge clk);
        chk("pipe_addr_ok0", {31'b0, d0_addr_ok}, 32'd1);
        chk("pipe_data_ok0", {31'b0, d0_data_ok}, 32'd0);
        @(posedge clk); #1; d0_addr = 32'h4;
        @(negedge clk);
        chk("pipe_addr_ok1", {31'b0, d0_addr_ok}, 32'd1);
        chk("pipe_data_ok1", {31'b0, d0_data_ok}, 32'd1);
        chk("pipe_rdata1", d0_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1; d0_addr = 32'h8;
        @(negedge clk);
        chk("pipe_addr_ok2", {31'b0, d0_addr_ok}, 32'd1);
        chk("pipe_data_ok2", {31'b0, d0_data_ok}, 32'd1);
        chk("pipe_rdata2", d0_rdata, 32'hAA22_33DD);
        @(posedge clk); #1; d0_req = 0;
        @(negedge clk);
        chk("pipe_data_ok3", {31'b0, d0_data_ok}, 32'd1);
        chk("pipe_rdata3", d0_rdata, 32'h5566_7788);
        @(negedge clk);
        chk("pipe_idle_data_ok", {31'b0, d0_data_ok}, 32'd0);
        chk("pipe_idle_rdata", d0_rdata, 32'd0);
        @(posedge clk); #1;

        // random traffic on the stalling instance; known contents first
        for (int i = 0; i < 16; i++) d1_op(1'b1, 32'(i * 4), 4'hf, $urandom);
        for (int i = 0; i < 200; i++) begin
            a = ($urandom << 14) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d1_op(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("d1_drain_pending", 32'(exp_q.size()), 32'd0);

        // reset with responses in flight
        d0_req = 1; d0_wr = 0; d0_addr = 32'h100;
        d1_req = 1; d1_wr = 0; d1_addr = 32'h0;
        @(posedge clk); #1;
        d0_addr = 32'h0; d1_addr = 32'h4;
        @(posedge clk); #1;
        d0_req = 0; d1_req = 0;
        reset = 1;
        @(negedge clk);
        chk("rst_mid_d0_data_ok", {31'b0, d0_data_ok}, 32'd0);
        chk("rst_mid_d0_addr_ok", {31'b0, d0_addr_ok}, 32'd0);
        chk("rst_mid_d0_rdata", d0_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_d0_data_ok[%0d]", i), {31'b0, d0_data_ok}, 32'd0);
            chk($sformatf("post_rst_d1_data_ok[%0d]", i), {31'b0, d1_data_ok}, 32'd0);
        end
        @(posedge clk); #1;

        // memory is untouched by reset
        d0_txn('{1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'h1234_AB78}, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
